// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer for the IF stage.
// Each entry holds valid, tag, target and a 2-bit saturating direction
// counter. Lookup on PC is combinational. Resolved branches from EX train
// the table through a single-cycle update port.
//
// Ports:
//   Clk        system clock, state updates on the rising edge
//   Reset      asynchronous active-high reset
//   PC         fetch PC to look up
//   PredTaken  PC-source mux select, 1 selects PredTarget
//   PredTarget predicted target, 0 on a miss
//   Hit        PC matched a valid entry, regardless of the counter
//   Clear      synchronous invalidate of all entries
//   UpdValid   a branch resolved in EX this cycle
//   UpdPC      PC of the resolved branch
//   UpdTaken   actual outcome of the resolved branch
//   UpdTarget  actual target of the resolved branch
module btb_predictor #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned TAG_BITS   = 32 - INDEX_BITS - 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PC,
  output logic        PredTaken,
  output logic [31:0] PredTarget,
  output logic        Hit,
  input  logic        Clear,
  input  logic        UpdValid,
  input  logic [31:0] UpdPC,
  input  logic        UpdTaken,
  input  logic [31:0] UpdTarget
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  // Register-based storage so every entry can be reset asynchronously.
  logic                valid  [ENTRIES];
  logic [TAG_BITS-1:0] tag    [ENTRIES];
  logic [31:0]         target [ENTRIES];
  logic [1:0]          ctr    [ENTRIES];

  logic [INDEX_BITS-1:0] lidx;
  logic [TAG_BITS-1:0]   ltag;
  logic [INDEX_BITS-1:0] uidx;
  logic [TAG_BITS-1:0]   utag;
  logic                  uhit;

  // The byte offset within a word plays no part in indexing or tagging.
  logic unused_low_bits;
  assign unused_low_bits = ^{PC[1:0], UpdPC[1:0]};

  assign lidx = PC[INDEX_BITS+1:2];
  assign ltag = PC[31:INDEX_BITS+2];
  assign uidx = UpdPC[INDEX_BITS+1:2];
  assign utag = UpdPC[31:INDEX_BITS+2];
  assign uhit = valid[uidx] && (tag[uidx] == utag);

  // Lookup path: reads pre-edge contents, there is no update bypass.
  always_comb begin
    Hit        = valid[lidx] && (tag[lidx] == ltag);
    PredTaken  = Hit && ctr[lidx][1];
    PredTarget = Hit ? target[lidx] : 32'h0;
  end

  // Table state: reset, invalidate-all, then training.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= 32'h0;
        ctr[i]    <= 2'b01;
      end
    end else if (Clear) begin
      // Clear wins over a simultaneous update, which is dropped.
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
      end
    end else if (UpdValid) begin
      if (uhit) begin
        if (UpdTaken) begin
          target[uidx] <= UpdTarget;
          if (ctr[uidx] != 2'b11) begin
            ctr[uidx] <= ctr[uidx] + 2'd1;
          end
        end else if (ctr[uidx] != 2'b00) begin
          ctr[uidx] <= ctr[uidx] - 2'd1;
        end
      end else if (UpdTaken) begin
        // Allocate or replace an aliasing entry, starting weakly taken.
        valid[uidx]  <= 1'b1;
        tag[uidx]    <= utag;
        target[uidx] <= UpdTarget;
        ctr[uidx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed stimulus against btb_predictor with a
// behavioural table model checked every falling edge, plus hand-computed
// literal expectations at key points of each scenario.
module tb_btb_predictor;

  logic        Clk;
  logic        Reset;
  logic [31:0] PC;
  logic        PredTaken;
  logic [31:0] PredTarget;
  logic        Hit;
  logic        Clear;
  logic        UpdValid;
  logic [31:0] UpdPC;
  logic        UpdTaken;
  logic [31:0] UpdTarget;

  int passed;
  int total;

  btb_predictor dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .PC         (PC),
    .PredTaken  (PredTaken),
    .PredTarget (PredTarget),
    .Hit        (Hit),
    .Clear      (Clear),
    .UpdValid   (UpdValid),
    .UpdPC      (UpdPC),
    .UpdTaken   (UpdTaken),
    .UpdTarget  (UpdTarget)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Model: each slot remembers the full PC of the branch it holds, so a
  // lookup hits when both PCs fall in the same 64-byte-aligned region.
  bit          m_valid  [16];
  logic [31:0] m_pc     [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];

  function automatic int slot_of(logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int s;
    s = slot_of(pc);
    return m_valid[s] && ((m_pc[s] / 64) == (pc / 64));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i]  = 1'b0;
      m_pc[i]     = 32'h0;
      m_target[i] = 32'h0;
      m_ctr[i]    = 1;
    end
  endtask

  initial m_reset();

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_reset();
    end else if (Clear) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    end else if (UpdValid) begin
      int s;
      s = slot_of(UpdPC);
      if (m_hit(UpdPC)) begin
        if (UpdTaken) begin
          m_ctr[s]    = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
          m_target[s] = UpdTarget;
        end else begin
          m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (UpdTaken) begin
        m_valid[s]  = 1'b1;
        m_pc[s]     = UpdPC;
        m_target[s] = UpdTarget;
        m_ctr[s]    = 2;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Continuous compare against the model, mid-cycle.
  always @(negedge Clk) begin
    bit          eh;
    bit          et;
    logic [31:0] eg;
    eh = m_hit(PC);
    et = eh && (m_ctr[slot_of(PC)] >= 2);
    eg = eh ? m_target[slot_of(PC)] : 32'h0;
    chk("model_hit", 32'(Hit), 32'(eh));
    chk("model_taken", 32'(PredTaken), 32'(et));
    chk("model_target", PredTarget, eg);
  end

  task automatic tick();
    @(posedge Clk);
    #2;
    UpdValid = 1'b0;
    Clear    = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    UpdValid  = 1'b1;
    UpdPC     = pc;
    UpdTaken  = tk;
    UpdTarget = tgt;
  endtask

  // Direct look at the combinational outputs for one PC.
  task automatic look(input string name, input logic [31:0] pc,
                      input logic eh, input logic et, input logic [31:0] eg);
    PC = pc;
    #1;
    chk({name, "_hit"}, 32'(Hit), 32'(eh));
    chk({name, "_taken"}, 32'(PredTaken), 32'(et));
    chk({name, "_target"}, PredTarget, eg);
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    Reset     = 1'b1;
    Clear     = 1'b0;
    UpdValid  = 1'b0;
    UpdPC     = 32'h0;
    UpdTaken  = 1'b0;
    UpdTarget = 32'h0;
    PC        = 32'h0040_0010;

    // Outputs are zero during reset before any clock edge.
    #2;
    look("reset_noclk", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    Reset = 1'b0;

    // Fill some entries, then reset while they are live.
    upd(32'h0040_0010, 1'b1, 32'h0040_0aa0); tick();
    upd(32'h0040_0024, 1'b1, 32'h0040_0bb0); tick();
    look("prefill", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0aa0);
    Reset = 1'b1;
    #1;
    look("reset_live", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
    tick();
    Reset = 1'b0;
    tick();
    look("after_reset", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
    look("after_reset2", 32'h0040_0024, 1'b0, 1'b0, 32'h0);

    // Allocate: no same-cycle bypass, visible next cycle at Ctr=2.
    upd(32'h0040_0010, 1'b1, 32'h0040_0100);
    look("alloc_same", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
    tick();
    look("alloc_next", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
    look("low_bits_ignored", 32'h0040_0013, 1'b1, 1'b1, 32'h0040_0100);

    // Saturate at 3 (three taken from 2), then walk down with hysteresis.
    upd(32'h0040_0010, 1'b1, 32'h0040_0100); tick();
    upd(32'h0040_0010, 1'b1, 32'h0040_0100); tick();
    upd(32'h0040_0010, 1'b1, 32'h0040_0104); tick();
    look("sat3_target", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0104);
    upd(32'h0040_0010, 1'b0, 32'hdead_beef); tick();
    look("ctr2_still_taken", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0104);
    upd(32'h0040_0010, 1'b0, 32'hdead_beef); tick();
    look("ctr1_not_taken", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0104);
    upd(32'h0040_0010, 1'b0, 32'h0); tick();
    upd(32'h0040_0010, 1'b0, 32'h0); tick();
    // From 0, one taken gives 1: still not taken, so no wrap occurred.
    upd(32'h0040_0010, 1'b1, 32'h0040_0108); tick();
    look("sat0_then_taken", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0108);
    upd(32'h0040_0010, 1'b1, 32'h0040_0108); tick();
    look("ctr2_again", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0108);

    // Alias at index 4 with a different tag replaces the entry.
    upd(32'h0040_0050, 1'b1, 32'h0040_0200); tick();
    look("alias_old", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
    look("alias_new", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0200);
    upd(32'h0040_0090, 1'b0, 32'h0040_0300); tick();
    look("nt_miss_noop", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0200);
    look("nt_miss_noalloc", 32'h0040_0090, 1'b0, 1'b0, 32'h0);
    upd(32'h0040_0050, 1'b0, 32'h0); tick();
    look("alias_ctr_was2", 32'h0040_0050, 1'b1, 1'b0, 32'h0040_0200);

    // UpdValid=0 ignores the other update inputs.
    UpdPC = 32'h0040_0060; UpdTaken = 1'b1; UpdTarget = 32'h1234_5678;
    tick();
    look("updvalid_low", 32'h0040_0060, 1'b0, 1'b0, 32'h0);

    // Clear together with an update drops the update.
    upd(32'h0040_0000, 1'b1, 32'h0040_0400); tick();
    upd(32'h0040_0034, 1'b1, 32'h0040_0500); tick();
    look("pre_clear", 32'h0040_0034, 1'b1, 1'b1, 32'h0040_0500);
    upd(32'h0040_0020, 1'b1, 32'h0040_0600);
    Clear = 1'b1;
    tick();
    look("clear_a", 32'h0040_0020, 1'b0, 1'b0, 32'h0);
    look("clear_b", 32'h0040_0000, 1'b0, 1'b0, 32'h0);
    look("clear_c", 32'h0040_0034, 1'b0, 1'b0, 32'h0);
    look("clear_d", 32'h0040_0050, 1'b0, 1'b0, 32'h0);
    upd(32'h0040_0020, 1'b1, 32'h0040_0700); tick();
    look("realloc", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0700);
    upd(32'h0040_0020, 1'b0, 32'h0); tick();
    look("realloc_ctr2", 32'h0040_0020, 1'b1, 1'b0, 32'h0040_0700);

    // Async reset between edges while an update is pending.
    upd(32'h0040_0040, 1'b1, 32'h0040_0800);
    PC = 32'h0040_0020;
    #1;
    Reset = 1'b1;
    #1;
    look("async_drop", 32'h0040_0020, 1'b0, 1'b0, 32'h0);
    @(posedge Clk);
    #2;
    Reset    = 1'b0;
    UpdValid = 1'b0;
    tick();
    look("async_upd_lost", 32'h0040_0040, 1'b0, 1'b0, 32'h0);
    look("async_entry_gone", 32'h0040_0020, 1'b0, 1'b0, 32'h0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
